upcount_ctrl: RTL and testbench

UPCOUNT_CTRL -- requirements
Module: upcount_ctrl

---
 rtl/upcount_ctrl.sv | 94 +++++++++
 tb/tb_upcount_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/upcount_ctrl.sv
// Loadable up-counter with IDLE/RUN/DONE control: counts toward a terminal value M,
// then either wraps to zero (continuous) or stops and flags completion (one-shot).
module upcount_ctrl #(
  parameter int unsigned n = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [n-1:0] R,
  input  logic [n-1:0] M,
  input  logic         L,
  input  logic         E,
  input  logic         C,
  output logic [n-1:0] Q,
  output logic         TC,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [n-1:0] q_q, q_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         at_term;

  assign at_term = (q_q == M);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    case (state_q)
      StIdle: begin
        if (L) begin
          q_d     = R;
          state_d = StRun;
        end
      end
      StRun: begin
        if (L) begin
          q_d = R;
        end else if (E) begin
          if (at_term) begin
            // Continuous mode wraps to zero; one-shot holds at M and finishes.
            if (C) begin
              q_d = '0;
            end else begin
              state_d = StDone;
            end
          end else begin
            q_d = q_q + n'(1);
          end
        end
      end
      StDone: begin
        if (L) begin
          q_d     = R;
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
        q_d     = '0;
      end
    endcase
    // Status flags are registered from the next state so they track the state register.
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign TC   = (state_q == StRun) && E && !L && at_term;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_upcount_ctrl.sv
// Self-checking bench for upcount_ctrl: directed vector table for the named scenarios,
// then randomized traffic compared against a rule-level reference model.
module tb_upcount_ctrl;

  logic       Clock;
  logic       Reset;
  logic [7:0] R;
  logic [7:0] M;
  logic       L;
  logic       E;
  logic       C;
  logic [7:0] Q;
  logic       TC;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;

  upcount_ctrl #(.n(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .R     (R),
    .M     (M),
    .L     (L),
    .E     (E),
    .C     (C),
    .Q     (Q),
    .TC    (TC),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst;
    logic       l;
    logic       e;
    logic       c;
    logic [7:0] r;
    logic [7:0] m;
    logic       tc;   // expected TC just before the edge
    logic [7:0] q;    // expected Q after the edge
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, l, e, c, input logic [7:0] r, m,
                     input logic tc, input logic [7:0] q, input logic busy, done);
    vec_t v;
    v.rst = rst; v.l = l; v.e = e; v.c = c; v.r = r; v.m = m;
    v.tc = tc; v.q = q; v.busy = busy; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, l, e, c, input logic [7:0] r, m);
    Reset = rst; L = l; E = e; C = c; R = r; M = m;
  endtask

  // Reference model: state 0=IDLE 1=RUN 2=DONE, count kept as a plain integer.
  int ref_st;
  int ref_q;

  function automatic logic ref_tc(input logic l, e, input int m);
    return (ref_st == 1) && e && !l && (ref_q == m);
  endfunction

  task automatic ref_edge(input logic rst, l, e, c, input int r, m);
    if (rst) begin
      ref_st = 0;
      ref_q  = 0;
    end else if (l) begin
      ref_q  = r;
      ref_st = 1;
    end else if (ref_st == 1 && e) begin
      if (ref_q != m)  ref_q = (ref_q + 1) % 256;
      else if (c)      ref_q = 0;
      else             ref_st = 2;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge Clock);
    @(negedge Clock);

    // Reset dominates load and enable.
    for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 8'h05, 8'h00, 0, 8'h00, 0, 0);
    // One-shot: load 1, count to 4, stop in DONE, E ignored afterwards.
    add(0, 1, 0, 0, 8'h01, 8'h04, 0, 8'h01, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h04, 0, 8'h02, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h04, 0, 8'h03, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h04, 0, 8'h04, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h04, 1, 8'h04, 0, 1);
    add(0, 0, 1, 0, 8'h00, 8'h04, 0, 8'h04, 0, 1);
    // Continuous, M=3: wrap to 0, TC once per lap, E=0 freezes.
    add(0, 1, 1, 1, 8'h00, 8'h03, 0, 8'h00, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 0, 8'h01, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 0, 8'h02, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 0, 8'h03, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 1, 8'h00, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 0, 8'h01, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 0, 8'h02, 1, 0);
    add(0, 0, 0, 1, 8'h00, 8'h03, 0, 8'h02, 1, 0);
    add(0, 0, 0, 1, 8'h00, 8'h03, 0, 8'h02, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 0, 8'h03, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 1, 8'h00, 1, 0);
    // Loaded value above M: count through the all-ones wrap, no early TC.
    add(0, 1, 1, 0, 8'hFE, 8'h01, 0, 8'hFE, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 8'hFF, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 8'h00, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 8'h01, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 1, 8'h01, 0, 1);
    // Load at Q==M suppresses TC and reloads.
    add(0, 1, 0, 1, 8'h03, 8'h03, 0, 8'h03, 1, 0);
    add(0, 1, 1, 1, 8'h10, 8'h03, 0, 8'h10, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h03, 0, 8'h11, 1, 0);
    // Reset mid-count, then E alone cannot leave IDLE.
    add(0, 1, 0, 0, 8'h00, 8'h08, 0, 8'h00, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h08, 0, 8'h01, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h08, 0, 8'h02, 1, 0);
    add(1, 0, 1, 0, 8'h00, 8'h08, 0, 8'h00, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h08, 0, 8'h00, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h08, 0, 8'h00, 0, 0);
    // M==0 continuous: Q stays 0, TC on every enabled non-load cycle.
    add(0, 1, 1, 1, 8'h00, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h00, 1, 8'h00, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h00, 1, 8'h00, 1, 0);
    add(0, 1, 1, 1, 8'h00, 8'h00, 0, 8'h00, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].l, vecs[i].e, vecs[i].c, vecs[i].r, vecs[i].m);
      #1;
      chk("vec_tc", i, TC, vecs[i].tc);
      @(posedge Clock);
      #1;
      chk("vec_q", i, Q, vecs[i].q);
      chk("vec_busy", i, Busy, vecs[i].busy);
      chk("vec_done", i, Done, vecs[i].done);
      @(negedge Clock);
    end

    // Randomized phase; leave with a clean reset so the model is in sync.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge Clock);
    @(negedge Clock);
    ref_st = 0;
    ref_q  = 0;
    for (int i = 0; i < 3000; i++) begin
      logic       rst, l, e, c;
      logic [7:0] r, m;
      rst = ($urandom_range(0, 39) == 0);
      l   = ($urandom_range(0, 9) == 0);
      e   = ($urandom_range(0, 3) != 0);
      c   = (i % 400 < 200) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      m   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      // Hold M steady most of the time so terminal events actually happen.
      if ($urandom_range(0, 15) != 0 && i > 0) m = M;
      drive(rst, l, e, c, r, m);
      #1;
      // Reset raised between edges must not disturb the outputs yet.
      chk("rnd_tc", i, TC, ref_tc(l, e, m));
      chk("rnd_q_pre", i, Q, ref_q);
      chk("rnd_busy_pre", i, Busy, ref_st == 1);
      @(posedge Clock);
      ref_edge(rst, l, e, c, r, m);
      #1;
      chk("rnd_q", i, Q, ref_q);
      chk("rnd_busy", i, Busy, ref_st == 1);
      chk("rnd_done", i, Done, ref_st == 2);
      chk("rnd_excl", i, Busy && Done, 0);
      @(negedge Clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
